alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 330 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential x86-style ALU: single-cycle arithmetic/logic, and shift/rotate that
// either steps one bit per clock or completes in a single cycle (BARREL != 0).
module alu_seq #(
    parameter int unsigned BARREL = 0,
    parameter int unsigned MAXCNT = 31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        group,
    input  logic [2:0]  alumode,
    input  logic        isize,
    input  logic        opsize,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [11:0] flags,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [11:0] flags_o
);
    localparam int unsigned W   = 32;
    localparam int unsigned WX  = W + 1;
    localparam int unsigned FW  = 12;
    localparam int unsigned CW  = 5;
    localparam logic [CW-1:0] CNT_MASK  = CW'(MAXCNT);
    localparam logic [FW-1:0] FLAGS_RST = 12'h002;
    localparam bit BARREL_EN = (BARREL != 0);

    localparam int unsigned F_C = 0;
    localparam int unsigned F_P = 2;
    localparam int unsigned F_A = 4;
    localparam int unsigned F_Z = 6;
    localparam int unsigned F_S = 7;
    localparam int unsigned F_T = 8;
    localparam int unsigned F_I = 9;
    localparam int unsigned F_D = 10;
    localparam int unsigned F_O = 11;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADC = 3'd2;
    localparam logic [2:0] OP_SBB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    localparam logic [2:0] SH_ROL = 3'd0;
    localparam logic [2:0] SH_ROR = 3'd1;
    localparam logic [2:0] SH_RCL = 3'd2;
    localparam logic [2:0] SH_RCR = 3'd3;
    localparam logic [2:0] SH_SHL = 3'd4;
    localparam logic [2:0] SH_SHR = 3'd5;
    localparam logic [2:0] SH_SAL = 3'd6;
    localparam logic [2:0] SH_SAR = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // wsel: 0 = 8-bit, 1 = 16-bit, 2 = 32-bit
    function automatic logic [W-1:0] width_mask(input logic [1:0] wsel);
        case (wsel)
            2'd0:    return 32'h0000_00FF;
            2'd1:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic msb_of(input logic [W-1:0] v, input logic [1:0] wsel);
        case (wsel)
            2'd0:    return v[7];
            2'd1:    return v[15];
            default: return v[31];
        endcase
    endfunction

    function automatic logic msb2_of(input logic [W-1:0] v, input logic [1:0] wsel);
        case (wsel)
            2'd0:    return v[6];
            2'd1:    return v[14];
            default: return v[30];
        endcase
    endfunction

    function automatic logic [W-1:0] top_bit(input logic b, input logic [1:0] wsel);
        case (wsel)
            2'd0:    return {24'd0, b, 7'd0};
            2'd1:    return {16'd0, b, 15'd0};
            default: return {b, 31'd0};
        endcase
    endfunction

    // One-bit shift/rotate of a width-masked value; returns {carry, value}
    function automatic logic [WX-1:0] shift_step(input logic [W-1:0] v, input logic cf,
                                                 input logic [2:0] mode, input logic [1:0] wsel);
        logic hi;
        logic lo;
        logic [W-1:0] nv;
        logic nc;
        hi = msb_of(v, wsel);
        lo = v[0];
        nv = v;
        nc = cf;
        case (mode)
            SH_ROL:         begin nv = (v << 1) | W'(hi);            nc = hi; end
            SH_ROR:         begin nv = (v >> 1) | top_bit(lo, wsel); nc = lo; end
            SH_RCL:         begin nv = (v << 1) | W'(cf);            nc = hi; end
            SH_RCR:         begin nv = (v >> 1) | top_bit(cf, wsel); nc = lo; end
            SH_SHL, SH_SAL: begin nv = v << 1;                       nc = hi; end
            SH_SHR:         begin nv = v >> 1;                       nc = lo; end
            default:        begin nv = (v >> 1) | top_bit(hi, wsel); nc = lo; end
        endcase
        return {nc, nv & width_mask(wsel)};
    endfunction

    // Single-cycle form: the same step unrolled, so it matches the iterative path bit for bit
    function automatic logic [WX-1:0] shift_n(input logic [W-1:0] v, input logic cf,
                                              input logic [2:0] mode, input logic [1:0] wsel,
                                              input logic [CW-1:0] c);
        logic [WX-1:0] acc;
        acc = {cf, v};
        for (int i = 0; i < 31; i++) begin
            if (CW'(i) < c) begin
                acc = shift_step(acc[W-1:0], acc[W], mode, wsel);
            end
        end
        return acc;
    endfunction

    function automatic logic [FW-1:0] shift_flags(input logic [W-1:0] r, input logic cf,
                                                  input logic [2:0] mode, input logic [1:0] wsel,
                                                  input logic src_msb, input logic [FW-1:0] fin);
        logic [FW-1:0] f;
        f = fin;
        f[F_C] = cf;
        case (mode)
            SH_ROL, SH_RCL, SH_SHL, SH_SAL: f[F_O] = msb_of(r, wsel) ^ cf;
            SH_SHR:                         f[F_O] = src_msb;
            SH_SAR:                         f[F_O] = 1'b0;
            default:                        f[F_O] = msb_of(r, wsel) ^ msb2_of(r, wsel);
        endcase
        // true shifts recompute S/Z/P; rotates keep them from the input flags
        if (mode[2]) begin
            f[F_S] = msb_of(r, wsel);
            f[F_Z] = (r == '0);
            f[F_P] = ~^r[7:0];
            f[F_A] = 1'b0;
        end
        f[1] = 1'b1;
        f[3] = 1'b0;
        f[5] = 1'b0;
        return f;
    endfunction

    // Arithmetic/logic group; returns {result, flags}
    function automatic logic [W+FW-1:0] alu_op(input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                                               input logic [FW-1:0] fin, input logic [2:0] mode,
                                               input logic [1:0] wsel);
        logic [W-1:0] m;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic [WX-1:0] ext;
        logic [FW-1:0] f;
        logic cin;
        logic arith;
        logic sub;
        logic cout;
        m     = width_mask(wsel);
        a     = a_in & m;
        b     = b_in & m;
        cin   = fin[F_C];
        arith = 1'b1;
        sub   = 1'b0;
        case (mode)
            OP_ADD:         ext = {1'b0, a} + {1'b0, b};
            OP_ADC:         ext = {1'b0, a} + {1'b0, b} + WX'(cin);
            OP_SBB:         begin ext = {1'b0, a} - {1'b0, b} - WX'(cin); sub = 1'b1; end
            OP_SUB, OP_CMP: begin ext = {1'b0, a} - {1'b0, b};            sub = 1'b1; end
            OP_OR:          begin ext = {1'b0, a | b}; arith = 1'b0; end
            OP_AND:         begin ext = {1'b0, a & b}; arith = 1'b0; end
            default:        begin ext = {1'b0, a ^ b}; arith = 1'b0; end
        endcase
        r = ext[W-1:0] & m;
        // carry/borrow is the bit just above the active width
        case (wsel)
            2'd0:    cout = ext[8];
            2'd1:    cout = ext[16];
            default: cout = ext[32];
        endcase
        f      = '0;
        f[F_D] = fin[F_D];
        f[F_I] = fin[F_I];
        f[F_T] = fin[F_T];
        f[1]   = 1'b1;
        f[F_S] = msb_of(r, wsel);
        f[F_Z] = (r == '0);
        f[F_P] = ~^r[7:0];
        if (arith) begin
            f[F_C] = cout;
            f[F_A] = a[4] ^ b[4] ^ r[4];
            if (sub) begin
                f[F_O] = (msb_of(a, wsel) != msb_of(b, wsel)) && (msb_of(r, wsel) != msb_of(a, wsel));
            end else begin
                f[F_O] = (msb_of(a, wsel) == msb_of(b, wsel)) && (msb_of(r, wsel) != msb_of(a, wsel));
            end
        end
        return {r, f};
    endfunction

    state_t         state, state_next;
    logic [W-1:0]   work, work_next;
    logic           work_c, work_c_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [2:0]     op_mode, op_mode_next;
    logic [1:0]     op_wsel, op_wsel_next;
    logic           src_msb, src_msb_next;
    logic [FW-1:0]  src_flags, src_flags_next;
    logic [W-1:0]   result_next;
    logic [FW-1:0]  flags_o_next;
    logic           busy_next;
    logic           done_next;

    logic [1:0]      wsel_in;
    logic [CW-1:0]   cnt_in;
    logic [W-1:0]    op1_m;
    logic [W+FW-1:0] alu_res;
    logic [WX-1:0]   bar_res;
    logic [WX-1:0]   step_res;

    // Operand decode straight from the inputs, used only on the start cycle
    assign wsel_in  = isize ? (opsize ? 2'd2 : 2'd1) : 2'd0;
    assign cnt_in   = op2[CW-1:0] & CNT_MASK;
    assign op1_m    = op1 & width_mask(wsel_in);
    assign alu_res  = alu_op(op1, op2, flags, alumode, wsel_in);
    assign bar_res  = shift_n(op1_m, flags[F_C], alumode, wsel_in, cnt_in);
    assign step_res = shift_step(work, work_c, op_mode, op_wsel);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            work      <= '0;
            work_c    <= 1'b0;
            cnt       <= '0;
            op_mode   <= '0;
            op_wsel   <= '0;
            src_msb   <= 1'b0;
            src_flags <= '0;
            result    <= '0;
            flags_o   <= FLAGS_RST;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            work      <= work_next;
            work_c    <= work_c_next;
            cnt       <= cnt_next;
            op_mode   <= op_mode_next;
            op_wsel   <= op_wsel_next;
            src_msb   <= src_msb_next;
            src_flags <= src_flags_next;
            result    <= result_next;
            flags_o   <= flags_o_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    always_comb begin
        state_next     = state;
        work_next      = work;
        work_c_next    = work_c;
        cnt_next       = cnt;
        op_mode_next   = op_mode;
        op_wsel_next   = op_wsel;
        src_msb_next   = src_msb;
        src_flags_next = src_flags;
        result_next    = result;
        flags_o_next   = flags_o;

        case (state)
            IDLE: begin
                if (start) begin
                    op_mode_next   = alumode;
                    op_wsel_next   = wsel_in;
                    src_msb_next   = msb_of(op1_m, wsel_in);
                    src_flags_next = flags;
                    if (!group) begin
                        state_next                  = FIN;
                        {result_next, flags_o_next} = alu_res;
                    end else if (cnt_in == '0) begin
                        state_next   = FIN;
                        result_next  = op1_m;
                        flags_o_next = flags;
                    end else if (BARREL_EN) begin
                        state_next   = FIN;
                        result_next  = bar_res[W-1:0];
                        flags_o_next = shift_flags(bar_res[W-1:0], bar_res[W], alumode, wsel_in,
                                                   msb_of(op1_m, wsel_in), flags);
                    end else begin
                        state_next  = RUN;
                        work_next   = op1_m;
                        work_c_next = flags[F_C];
                        cnt_next    = cnt_in;
                    end
                end
            end
            RUN: begin
                work_next   = step_res[W-1:0];
                work_c_next = step_res[W];
                cnt_next    = cnt - CW'(1);
                if (cnt <= CW'(1)) begin
                    state_next   = FIN;
                    result_next  = step_res[W-1:0];
                    flags_o_next = shift_flags(step_res[W-1:0], step_res[W], op_mode, op_wsel,
                                               src_msb, src_flags);
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
        done_next = (state_next == FIN);
    end
endmodule
